axil_rd_arbiter: RTL and testbench
==================================

Name: axil_rd_arbiter

Overview:
Round-robin arbiter that shares one AXI4-Lite read master port between S_COUNT AXI4-Lite read requesters. It sits in front of a single downstream slave, such as the read adapter or a register bank. It accepts one read at a time from the granted requester, forwards it downstream, and routes the response back to that requester only. It allows one outstanding transaction in total, and all outputs are registered.

Parameters:
S_COUNT, 2, number of requester (slave) ports; legal range 2..8.
ADDR_WIDTH, 32, address width in bits.
DATA_WIDTH, 32, data width in bits; the same on all ports.

Ports:
clk  in  1  clock; all logic on rising edge.
rstn  in  1  asynchronous active-low reset.
s_axil_araddr  in  S_COUNT*ADDR_WIDTH  per-port read address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
s_axil_arvalid  in  S_COUNT  per-port address valid.
s_axil_arready  out  S_COUNT  per-port address ready.
s_axil_rdata  out  S_COUNT*DATA_WIDTH  per-port read data; the same register is driven to all ports.
s_axil_rresp  out  S_COUNT*2  per-port read response; the same register is driven to all ports.
s_axil_rvalid  out  S_COUNT  per-port read data valid.
s_axil_rready  in  S_COUNT  per-port read data ready.
m_axil_araddr  out  ADDR_WIDTH  downstream address.
m_axil_arvalid  out  1  downstream address valid.
m_axil_arready  in  1  downstream address ready.
m_axil_rdata  in  DATA_WIDTH  downstream read data.
m_axil_rresp  in  2  downstream read response.
m_axil_rvalid  in  1  downstream read valid.
m_axil_rready  out  1  downstream read ready.
grant_idx  out  $clog2(S_COUNT)  index of the current or last granted port; used for debug and coverage.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0: arready, rvalid, rdata, rresp, m_araddr, m_arvalid, m_rready, grant_idx.
  - Round-robin pointer last=S_COUNT-1, so port 0 has first priority.
  - Assertion mid-transaction aborts it immediately; no recovery and no partial response.
- State machine: IDLE -> ACCEPT -> ADDR -> DATA -> RESP -> IDLE.
- IDLE:
  - If any arvalid is high at cycle T, grant the first requesting port searching from last+1 upward with wrap.
  - Register grant_idx; go to ACCEPT.
  - If no arvalid is high, stay in IDLE.
- ACCEPT (T+1):
  - s_axil_arready[g]=1 for exactly this one cycle; all other arready bits stay 0.
  - Requesters hold arvalid/araddr per AXI, so the handshake completes here.
  - Capture araddr[g] into m_axil_araddr; m_axil_arvalid=1 from T+2; go to ADDR.
- ADDR:
  - Hold m_arvalid and m_araddr stable until m_arready.
  - On the handshake: m_arvalid=0, m_rready=1 next cycle, go to DATA.
- DATA:
  - On m_rvalid && m_rready: capture rdata/rresp; s_axil_rvalid[g]=1 next cycle; m_rready=0; go to RESP.
  - m_rvalid arriving before DATA is held by the downstream slave and accepted when m_rready rises.
- RESP:
  - Hold s_rvalid[g], rdata and rresp until s_rready[g].
  - On the handshake: s_rvalid=0, last=g, go to IDLE. The next grant is evaluated in that IDLE cycle.
- Invariants:
  - At most one s_rvalid bit high at any time.
  - s_arready is one-hot or zero.
  - No new grant while a transaction is in flight.
- Latency: request seen at T -> m_arvalid at T+2. Downstream R handshake at U -> s_rvalid at U+1.
- rresp passes through unmodified (OKAY/EXOKAY/SLVERR/DECERR).
- Undefined behaviour (not checked): a requester dropping arvalid before arready.

Decomposition:
- Shared package axil_arb_pkg holds:
  - the state encoding (IDLE, ACCEPT, ADDR, DATA, RESP; 3 bits);
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- One sub-module, rr_arbiter: purely combinational. Inputs are the request vector and the last pointer; outputs are grant_valid and grant_idx. It is reused later by the write arbiter.

Test Plan:
1. Single read, port0 addr 0x0000_1000; downstream returns 0xDEADBEEF/OKAY. Required:
   - arready[0] pulses 1 cycle after arvalid;
   - m_araddr=0x1000 with m_arvalid 2 cycles after request;
   - port0 rdata=0xDEADBEEF, rresp=00; port1 rvalid stays 0.
2. After reset, port0 (0x10) and port1 (0x20) request in the same cycle. Required: port0 served first, then port1; m_araddr sequence is 0x10, 0x20.
3. Both ports request continuously for 4 transactions each. Required: grant_idx sequence 0,1,0,1,0,1,0,1; neither port starves.
4. Backpressure: m_arready low 5 cycles, then m_rvalid delayed 4 cycles, then s_rready low 3 cycles. Required:
   - m_araddr/m_arvalid stable throughout;
   - s_rvalid held with stable data;
   - no arready to the other port until RESP completes.
5. Port1 read with downstream rresp=2'b10 and data 0x0BAD0BAD. Required: port1 receives rresp=10, data 0x0BAD0BAD.
6. rstn asserted in DATA state. Required:
   - all outputs 0 without waiting for a clock;
   - after release, a fresh port1 read completes normally and port0 again has first priority.

Source files
------------

// File: rtl/axil_arb_pkg.sv
// Shared types for the AXI4-Lite arbiters: FSM state encoding and response codes.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    RESP   = 3'd4
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward from last+1 with wrap.
module rr_arbiter #(
  parameter int S_COUNT = 2,
  parameter int IDX_W   = $clog2(S_COUNT)
) (
  input  logic [S_COUNT-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  localparam int unsigned N = S_COUNT;

  int unsigned pos;

  // Walk the candidates farthest-first so the nearest requester after last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    pos         = 0;
    for (int i = S_COUNT; i >= 1; i--) begin
      pos = (32'(last) + 32'(i)) % N;
      if (req[IDX_W'(pos)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/axil_rd_arbiter.sv
// Round-robin AXI4-Lite read arbiter: S_COUNT requesters share one downstream read port,
// one transaction in flight, all outputs registered.
module axil_rd_arbiter
  import axil_arb_pkg::*;
#(
  parameter int S_COUNT    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [S_COUNT*ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [S_COUNT-1:0]              s_axil_arvalid,
  output logic [S_COUNT-1:0]              s_axil_arready,
  output logic [S_COUNT*DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [S_COUNT*2-1:0]            s_axil_rresp,
  output logic [S_COUNT-1:0]              s_axil_rvalid,
  input  logic [S_COUNT-1:0]              s_axil_rready,
  output logic [ADDR_WIDTH-1:0]           m_axil_araddr,
  output logic                            m_axil_arvalid,
  input  logic                            m_axil_arready,
  input  logic [DATA_WIDTH-1:0]           m_axil_rdata,
  input  logic [1:0]                      m_axil_rresp,
  input  logic                            m_axil_rvalid,
  output logic                            m_axil_rready,
  output logic [$clog2(S_COUNT)-1:0]      grant_idx
);

  localparam int IDX_W = $clog2(S_COUNT);

  arb_state_e              state, state_nxt;
  logic [IDX_W-1:0]        last_q;
  logic                    arb_vld;
  logic [IDX_W-1:0]        arb_idx;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;
  logic [ADDR_WIDTH-1:0]   araddr_arr [S_COUNT];
  logic                    ar_hs, r_hs, s_hs;

  for (genvar p = 0; p < S_COUNT; p++) begin : g_port
    assign araddr_arr[p] = s_axil_araddr[p*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // The response register is shared; only the granted port's rvalid qualifies it.
  assign s_axil_rdata = {S_COUNT{rdata_q}};
  assign s_axil_rresp = {S_COUNT{rresp_q}};

  assign ar_hs = m_axil_arvalid && m_axil_arready;
  assign r_hs  = m_axil_rvalid && m_axil_rready;
  assign s_hs  = s_axil_rvalid[grant_idx] && s_axil_rready[grant_idx];

  rr_arbiter #(
    .S_COUNT (S_COUNT),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req         (s_axil_arvalid),
    .last        (last_q),
    .grant_valid (arb_vld),
    .grant_idx   (arb_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_vld) state_nxt = ACCEPT;
      ACCEPT:  state_nxt = ADDR;
      ADDR:    if (ar_hs) state_nxt = DATA;
      DATA:    if (r_hs)  state_nxt = RESP;
      RESP:    if (s_hs)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q         <= IDX_W'(S_COUNT - 1);
      grant_idx      <= '0;
      s_axil_arready <= '0;
      s_axil_rvalid  <= '0;
      rdata_q        <= '0;
      rresp_q        <= '0;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (arb_vld) begin
          grant_idx      <= arb_idx;
          s_axil_arready <= S_COUNT'(1) << arb_idx;
        end
        ACCEPT: begin
          s_axil_arready <= '0;
          m_axil_araddr  <= araddr_arr[grant_idx];
          m_axil_arvalid <= 1'b1;
        end
        ADDR: if (ar_hs) begin
          m_axil_arvalid <= 1'b0;
          m_axil_rready  <= 1'b1;
        end
        DATA: if (r_hs) begin
          rdata_q       <= m_axil_rdata;
          rresp_q       <= m_axil_rresp;
          m_axil_rready <= 1'b0;
          s_axil_rvalid <= S_COUNT'(1) << grant_idx;
        end
        RESP: if (s_hs) begin
          s_axil_rvalid <= '0;
          last_q        <= grant_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Directed bench for axil_rd_arbiter with two requester ports.
module tb_axil_rd_arbiter;
  import axil_arb_pkg::*;

  localparam int S_COUNT = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                  clk;
  logic                  rstn;
  logic [S_COUNT*AW-1:0] s_axil_araddr;
  logic [S_COUNT-1:0]    s_axil_arvalid;
  logic [S_COUNT-1:0]    s_axil_arready;
  logic [S_COUNT*DW-1:0] s_axil_rdata;
  logic [S_COUNT*2-1:0]  s_axil_rresp;
  logic [S_COUNT-1:0]    s_axil_rvalid;
  logic [S_COUNT-1:0]    s_axil_rready;
  logic [AW-1:0]         m_axil_araddr;
  logic                  m_axil_arvalid;
  logic                  m_axil_arready;
  logic [DW-1:0]         m_axil_rdata;
  logic [1:0]            m_axil_rresp;
  logic                  m_axil_rvalid;
  logic                  m_axil_rready;
  logic [0:0]            grant_idx;

  int checks = 0;
  int errors = 0;

  axil_rd_arbiter #(.S_COUNT(S_COUNT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .m_axil_araddr  (m_axil_araddr),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_arready (m_axil_arready),
    .m_axil_rdata   (m_axil_rdata),
    .m_axil_rresp   (m_axil_rresp),
    .m_axil_rvalid  (m_axil_rvalid),
    .m_axil_rready  (m_axil_rready),
    .grant_idx      (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".arready"}, 64'(s_axil_arready), 64'h0);
    chk({tag, ".rvalid"},  64'(s_axil_rvalid),  64'h0);
    chk({tag, ".rdata"},   64'(s_axil_rdata),   64'h0);
    chk({tag, ".rresp"},   64'(s_axil_rresp),   64'h0);
    chk({tag, ".m_araddr"}, 64'(m_axil_araddr), 64'h0);
    chk({tag, ".m_arvalid"}, 64'(m_axil_arvalid), 64'h0);
    chk({tag, ".m_rready"}, 64'(m_axil_rready), 64'h0);
    chk({tag, ".grant_idx"}, 64'(grant_idx), 64'h0);
  endtask

  // Entered in an IDLE cycle with the request(s) already driven; leaves in the next IDLE cycle.
  task automatic txn(input string tag, input int g, input logic [31:0] addr,
                     input logic [31:0] d, input logic [1:0] r, input bit drop);
    logic [S_COUNT-1:0] oh;
    oh = S_COUNT'(1) << g;
    tick();
    chk({tag, ".arready"},   64'(s_axil_arready), 64'(oh));
    chk({tag, ".grant"},     64'(grant_idx), 64'(g));
    chk({tag, ".m_arvalid0"}, 64'(m_axil_arvalid), 64'h0);
    if (drop) s_axil_arvalid[g] = 1'b0;
    tick();
    chk({tag, ".arready_off"}, 64'(s_axil_arready), 64'h0);
    chk({tag, ".m_arvalid"}, 64'(m_axil_arvalid), 64'h1);
    chk({tag, ".m_araddr"},  64'(m_axil_araddr), 64'(addr));
    m_axil_arready = 1'b1;
    tick();
    m_axil_arready = 1'b0;
    chk({tag, ".m_arvalid_off"}, 64'(m_axil_arvalid), 64'h0);
    chk({tag, ".m_rready"}, 64'(m_axil_rready), 64'h1);
    m_axil_rvalid = 1'b1;
    m_axil_rdata  = d;
    m_axil_rresp  = r;
    tick();
    m_axil_rvalid = 1'b0;
    chk({tag, ".rvalid"},   64'(s_axil_rvalid), 64'(oh));
    chk({tag, ".rdata"},    64'(s_axil_rdata[g*DW +: DW]), 64'(d));
    chk({tag, ".rresp"},    64'(s_axil_rresp[g*2 +: 2]), 64'(r));
    chk({tag, ".m_rready_off"}, 64'(m_axil_rready), 64'h0);
    s_axil_rready[g] = 1'b1;
    tick();
    s_axil_rready[g] = 1'b0;
    chk({tag, ".rvalid_off"}, 64'(s_axil_rvalid), 64'h0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    rstn           = 1'b0;
    s_axil_araddr  = '0;
    s_axil_arvalid = '0;
    s_axil_rready  = '0;
    m_axil_arready = 1'b0;
    m_axil_rdata   = '0;
    m_axil_rresp   = '0;
    m_axil_rvalid  = 1'b0;
    #1;
    chk_all_zero("reset");
    do_reset();

    // Single port0 read
    s_axil_araddr[0 +: AW] = 32'h0000_1000;
    s_axil_arvalid[0] = 1'b1;
    txn("t1", 0, 32'h0000_1000, 32'hDEAD_BEEF, RESP_OKAY, 1'b1);

    // Simultaneous requests right after reset: port0 first
    do_reset();
    s_axil_araddr  = {32'h20, 32'h10};
    s_axil_arvalid = 2'b11;
    txn("t2a", 0, 32'h10, 32'h1111_0000, RESP_OKAY, 1'b1);
    txn("t2b", 1, 32'h20, 32'h2222_0000, RESP_OKAY, 1'b1);

    // Continuous requests alternate
    s_axil_araddr  = {32'hB000, 32'hA000};
    s_axil_arvalid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      txn($sformatf("t3[%0d]", i), i % 2, (i % 2) ? 32'hB000 : 32'hA000,
          32'h3000_0000 + 32'(i), RESP_OKAY, i >= 6);
    end

    // Backpressure on every channel with port1 waiting
    s_axil_araddr  = {32'h800, 32'h400};
    s_axil_arvalid = 2'b11;
    tick();
    chk("t4.arready", 64'(s_axil_arready), 64'h1);
    s_axil_arvalid[0] = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4.ar_hold_v", 64'(m_axil_arvalid), 64'h1);
      chk("t4.ar_hold_a", 64'(m_axil_araddr), 64'h400);
      chk("t4.ar_other", 64'(s_axil_arready), 64'h0);
      tick();
    end
    m_axil_arready = 1'b1;
    tick();
    m_axil_arready = 1'b0;
    chk("t4.m_rready", 64'(m_axil_rready), 64'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4.r_wait_rready", 64'(m_axil_rready), 64'h1);
      chk("t4.r_wait_rvalid", 64'(s_axil_rvalid), 64'h0);
      chk("t4.r_wait_arready", 64'(s_axil_arready), 64'h0);
    end
    m_axil_rvalid = 1'b1;
    m_axil_rdata  = 32'h1234_5678;
    m_axil_rresp  = RESP_EXOKAY;
    tick();
    m_axil_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4.s_hold_v", 64'(s_axil_rvalid), 64'h1);
      chk("t4.s_hold_d", 64'(s_axil_rdata[0 +: DW]), 64'h1234_5678);
      chk("t4.s_hold_r", 64'(s_axil_rresp[1:0]), 64'(RESP_EXOKAY));
      chk("t4.s_other", 64'(s_axil_arready), 64'h0);
      if (i < 3) tick();
    end
    s_axil_rready[0] = 1'b1;
    tick();
    s_axil_rready[0] = 1'b0;
    chk("t4.done_rvalid", 64'(s_axil_rvalid), 64'h0);
    chk("t4.done_arready", 64'(s_axil_arready), 64'h0);

    // Port1, waiting since the previous test, gets an error response
    txn("t5", 1, 32'h800, 32'h0BAD_0BAD, RESP_SLVERR, 1'b1);

    // Reset mid-transaction: complete a port0 read, start port1, abort in DATA
    s_axil_araddr  = {32'h77, 32'h55};
    s_axil_arvalid = 2'b01;
    txn("t6a", 0, 32'h55, 32'hCAFE_F00D, RESP_DECERR, 1'b1);
    s_axil_arvalid = 2'b10;
    tick();
    chk("t6.arready", 64'(s_axil_arready), 64'h2);
    s_axil_arvalid = 2'b00;
    tick();
    m_axil_arready = 1'b1;
    tick();
    m_axil_arready = 1'b0;
    chk("t6.in_data", 64'(m_axil_rready), 64'h1);
    rstn = 1'b0;
    #1;
    chk_all_zero("t6.async");
    tick();
    tick();
    rstn = 1'b1;
    s_axil_arvalid = 2'b11;
    txn("t6b", 0, 32'h55, 32'h6060_6060, RESP_OKAY, 1'b1);
    txn("t6c", 1, 32'h77, 32'h7070_7070, RESP_OKAY, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
